// File: rtl/regread_if.sv
// Decode, writeback and execute-side bus of the register-read stage.
//   decode_*  : instruction presented by decode, decode_stall back-pressures it
//   wb_*      : register-file write port from writeback
//   exec_stall: execute cannot take a new instruction
//   read_*    : registered instruction and operands handed to execute
// master drives decode/writeback/exec_stall; slave is the register-read stage.
interface regread_if #(
  parameter int unsigned XLEN = 32
);
  logic            decode_valid;
  logic [6:0]      decode_opcode;
  logic [4:0]      decode_rd;
  logic [4:0]      decode_rs1;
  logic [4:0]      decode_rs2;
  logic [2:0]      decode_funct3;
  logic [6:0]      decode_funct7;
  logic [31:0]     decode_imm;
  logic [31:0]     decode_pc;
  logic [5:0]      decode_exception_num;
  logic            decode_exception_valid;
  logic            decode_stall;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_val;

  logic            exec_stall;

  logic            read_valid;
  logic [6:0]      read_opcode;
  logic [4:0]      read_rd;
  logic [4:0]      read_rs2;
  logic [2:0]      read_funct3;
  logic [6:0]      read_funct7;
  logic [31:0]     read_imm;
  logic [31:0]     read_pc;
  logic [XLEN-1:0] read_rs1_val;
  logic [XLEN-1:0] read_rs2_val;
  logic [5:0]      read_exception_num;
  logic            read_exception_valid;

  modport master (
    output decode_valid, decode_opcode, decode_rd, decode_rs1, decode_rs2,
           decode_funct3, decode_funct7, decode_imm, decode_pc,
           decode_exception_num, decode_exception_valid,
           wb_valid, wb_rd, wb_val, exec_stall,
    input  decode_stall,
           read_valid, read_opcode, read_rd, read_rs2, read_funct3, read_funct7,
           read_imm, read_pc, read_rs1_val, read_rs2_val,
           read_exception_num, read_exception_valid
  );

  modport slave (
    input  decode_valid, decode_opcode, decode_rd, decode_rs1, decode_rs2,
           decode_funct3, decode_funct7, decode_imm, decode_pc,
           decode_exception_num, decode_exception_valid,
           wb_valid, wb_rd, wb_val, exec_stall,
    output decode_stall,
           read_valid, read_opcode, read_rd, read_rs2, read_funct3, read_funct7,
           read_imm, read_pc, read_rs1_val, read_rs2_val,
           read_exception_num, read_exception_valid
  );
endinterface

// File: rtl/regread.sv
// Register-read stage of the in-order RV32I pipeline.
// Holds the 32-entry integer register file and a per-register busy scoreboard,
// stalls decode on RAW/WAW hazards and registers operands plus decoded fields
// for execute (one-cycle latency).
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   flush : kill the staged instruction and clear the scoreboard
//   bus   : decode / writeback / execute bus (regread_if.slave)
// decode_stall is combinational (exec_stall or hazard).
module regread #(
  parameter int unsigned XLEN      = 32,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  regread_if.slave bus
);

  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic            rs1_used;
  logic            rs2_used;
  logic            rd_writes;
  logic            rs1_byp;
  logic            rs2_byp;
  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            haz_rd;
  logic            hazard;
  logic            capture;

  // Which register fields the opcode actually reads or writes; x0 never counts.
  always_comb begin
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    rd_writes = 1'b0;
    case (bus.decode_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: rs1_used = 1'b0;
      default:                     rs1_used = 1'b1;
    endcase
    case (bus.decode_opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: rs2_used = 1'b1;
      default:                       rs2_used = 1'b0;
    endcase
    case (bus.decode_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OPIMM, OPC_OP: rd_writes = 1'b1;
      default:                     rd_writes = 1'b0;
    endcase
    rs1_used  = rs1_used  && (bus.decode_rs1 != RW'(0));
    rs2_used  = rs2_used  && (bus.decode_rs2 != RW'(0));
    rd_writes = rd_writes && (bus.decode_rd  != RW'(0));
  end

  // Operand select: x0 is hard zero, then same-cycle writeback, then the array.
  always_comb begin
    rs1_byp = WB_BYPASS && bus.wb_valid && (bus.wb_rd == bus.decode_rs1)
              && (bus.decode_rs1 != RW'(0));
    rs2_byp = WB_BYPASS && bus.wb_valid && (bus.wb_rd == bus.decode_rs2)
              && (bus.decode_rs2 != RW'(0));

    rs1_val_c = regs[bus.decode_rs1];
    if (bus.decode_rs1 == RW'(0)) begin
      rs1_val_c = '0;
    end else if (rs1_byp) begin
      rs1_val_c = bus.wb_val;
    end

    rs2_val_c = regs[bus.decode_rs2];
    if (bus.decode_rs2 == RW'(0)) begin
      rs2_val_c = '0;
    end else if (rs2_byp) begin
      rs2_val_c = bus.wb_val;
    end
  end

  // Hazards: busy source not covered by bypass, or busy destination whose
  // pending write does not retire this cycle. Exceptions and flush skip it.
  always_comb begin
    haz_rs1 = rs1_used && busy[bus.decode_rs1] && !rs1_byp;
    haz_rs2 = rs2_used && busy[bus.decode_rs2] && !rs2_byp;
    haz_rd  = rd_writes && busy[bus.decode_rd]
              && !(bus.wb_valid && (bus.wb_rd == bus.decode_rd));
    hazard  = bus.decode_valid && !bus.decode_exception_valid && !flush
              && (haz_rs1 || haz_rs2 || haz_rd);
    capture = bus.decode_valid && !hazard && !bus.exec_stall && !flush;
  end

  assign bus.decode_stall = bus.exec_stall | hazard;

  // Scoreboard update: writeback clears, capture sets (set wins), flush clears all.
  always_comb begin
    busy_next = busy;
    if (bus.wb_valid) begin
      busy_next[bus.wb_rd] = 1'b0;
    end
    if (capture && rd_writes && !bus.decode_exception_valid) begin
      busy_next[bus.decode_rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Register file; writes to x0 are dropped and still land during flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_valid && (bus.wb_rd != RW'(0))) begin
      regs[bus.wb_rd] <= bus.wb_val;
    end
  end

  // Execute-facing pipeline register; fields only reload on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_valid           <= 1'b0;
      bus.read_opcode          <= '0;
      bus.read_rd              <= '0;
      bus.read_rs2             <= '0;
      bus.read_funct3          <= '0;
      bus.read_funct7          <= '0;
      bus.read_imm             <= '0;
      bus.read_pc              <= '0;
      bus.read_rs1_val         <= '0;
      bus.read_rs2_val         <= '0;
      bus.read_exception_num   <= '0;
      bus.read_exception_valid <= 1'b0;
    end else if (flush) begin
      bus.read_valid <= 1'b0;
    end else if (!bus.exec_stall) begin
      bus.read_valid <= capture;
      if (capture) begin
        bus.read_opcode          <= bus.decode_opcode;
        bus.read_rd              <= bus.decode_rd;
        bus.read_rs2             <= bus.decode_rs2;
        bus.read_funct3          <= bus.decode_funct3;
        bus.read_funct7          <= bus.decode_funct7;
        bus.read_imm             <= bus.decode_imm;
        bus.read_pc              <= bus.decode_pc;
        bus.read_rs1_val         <= rs1_val_c;
        bus.read_rs2_val         <= rs2_val_c;
        bus.read_exception_num   <= bus.decode_exception_num;
        bus.read_exception_valid <= bus.decode_exception_valid;
      end
    end
  end

endmodule

// File: tb/tb_regread.sv
// Directed bench for regread: expected stage outputs are queued when an
// instruction is driven and checked when it appears at the read_* outputs.
module tb_regread;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [5:0]  exc_num;
    logic        exc_valid;
  } rec_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  regread_if #(.XLEN(XLEN)) bus ();

  regread #(.XLEN(XLEN), .WB_BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          nvec  = 0;
  int          nfail = 0;
  logic [31:0] mregs [32];
  rec_t        sbq [$];
  rec_t        last = '0;
  logic [31:0] pc_ctr = 32'h0000_0100;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t obs, input rec_t exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op_val(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.wb_valid && bus.wb_rd == rs) return bus.wb_val;
    return mregs[rs];
  endfunction

  function automatic rec_t expect_now();
    rec_t r;
    r.opcode    = bus.decode_opcode;
    r.rd        = bus.decode_rd;
    r.rs2       = bus.decode_rs2;
    r.funct3    = bus.decode_funct3;
    r.funct7    = bus.decode_funct7;
    r.imm       = bus.decode_imm;
    r.pc        = bus.decode_pc;
    r.rs1_val   = op_val(bus.decode_rs1);
    r.rs2_val   = op_val(bus.decode_rs2);
    r.exc_num   = bus.decode_exception_num;
    r.exc_valid = bus.decode_exception_valid;
    return r;
  endfunction

  function automatic rec_t observed();
    rec_t r;
    r.opcode    = bus.read_opcode;
    r.rd        = bus.read_rd;
    r.rs2       = bus.read_rs2;
    r.funct3    = bus.read_funct3;
    r.funct7    = bus.read_funct7;
    r.imm       = bus.read_imm;
    r.pc        = bus.read_pc;
    r.rs1_val   = bus.read_rs1_val;
    r.rs2_val   = bus.read_rs2_val;
    r.exc_num   = bus.read_exception_num;
    r.exc_valid = bus.read_exception_valid;
    return r;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    bus.decode_valid           = 1'b1;
    bus.decode_opcode          = op;
    bus.decode_rd              = rd;
    bus.decode_rs1             = rs1;
    bus.decode_rs2             = rs2;
    bus.decode_funct3          = f3;
    bus.decode_funct7          = f7;
    bus.decode_imm             = imm;
    bus.decode_pc              = pc_ctr;
    bus.decode_exception_num   = 6'd0;
    bus.decode_exception_valid = 1'b0;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] val);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_val   = val;
  endtask

  // One clock: check decode_stall before the edge, read_valid and the
  // queued/held record after it.
  task automatic step(input string tag, input logic exp_stall, input logic exp_rv);
    rec_t e;
    logic cap;
    #1;
    chk_bit({tag, "/stall"}, bus.decode_stall, exp_stall);
    cap = !bus.exec_stall && !flush && exp_rv;
    if (cap) sbq.push_back(expect_now());
    @(posedge clk);
    if (bus.wb_valid && bus.wb_rd != 5'd0) mregs[bus.wb_rd] = bus.wb_val;
    #1;
    chk_bit({tag, "/valid"}, bus.read_valid, exp_rv);
    if (cap) begin
      e = sbq.pop_front();
      last = e;
      chk_rec({tag, "/data"}, observed(), e);
    end else if (exp_rv) begin
      chk_rec({tag, "/hold"}, observed(), last);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    reset = 1'b0;
    flush = 1'b0;
    bus.exec_stall = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    issue(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.decode_valid = 1'b0;
    pc_ctr = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset/valid", bus.read_valid, 1'b0);
    chk_rec("reset/data", observed(), '0);
    reset = 1'b1;

    // ADDI x1,x0,5
    issue(OPC_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step("addi_x1", 1'b0, 1'b1);

    // ADD x2,x1,x1 waits for x1, captured on the writeback cycle via bypass
    issue(OPC_OP, 5'd2, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    step("raw_wait0", 1'b1, 1'b0);
    step("raw_wait1", 1'b1, 1'b0);
    wb(1'b1, 5'd1, 32'd5);
    step("raw_bypass", 1'b0, 1'b1);
    wb(1'b0, 5'd0, 32'd0);

    // exec_stall holds the ADD while ADDI x4 waits behind it
    issue(OPC_OPIMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    bus.exec_stall = 1'b1;
    step("xstall0", 1'b1, 1'b1);
    step("xstall1", 1'b1, 1'b1);
    step("xstall2", 1'b1, 1'b1);
    bus.exec_stall = 1'b0;
    step("xstall_rel", 1'b0, 1'b1);
    bus.decode_valid = 1'b0;
    step("idle", 1'b0, 1'b0);

    // x0 writes are ignored and x0 reads zero
    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    issue(OPC_OP, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step("x0_read", 1'b0, 1'b1);
    wb(1'b0, 5'd0, 32'd0);
    issue(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step("rd0_a", 1'b0, 1'b1);
    issue(OPC_OPIMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step("rd0_b", 1'b0, 1'b1);
    issue(OPC_OP, 5'd6, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0);
    step("rf_x1", 1'b0, 1'b1);

    // Exception ignores busy x2 and sets nothing
    issue(OPC_OPIMM, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.decode_exception_valid = 1'b1;
    bus.decode_exception_num   = 6'd2;
    step("exc", 1'b0, 1'b1);
    issue(OPC_OPIMM, 5'd8, 5'd7, 5'd0, 3'd0, 7'd0, 32'd0);
    step("exc_nobusy", 1'b0, 1'b1);
    issue(OPC_OP, 5'd9, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0);
    step("x2_still_busy", 1'b1, 1'b0);
    wb(1'b1, 5'd2, 32'h22);
    step("x2_bypass", 1'b0, 1'b1);
    wb(1'b0, 5'd0, 32'd0);

    // Flush with exec_stall clears x3 busy
    issue(OPC_OPIMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step("x3_set", 1'b0, 1'b1);
    bus.decode_valid = 1'b0;
    bus.exec_stall = 1'b1;
    flush = 1'b1;
    step("flush_xs", 1'b1, 1'b0);
    flush = 1'b0;
    bus.exec_stall = 1'b0;
    issue(OPC_OP, 5'd10, 5'd3, 5'd3, 3'd0, 7'd0, 32'd0);
    step("x3_free", 1'b0, 1'b1);

    // Flush masks a hazard stall; writeback still lands
    issue(OPC_OP, 5'd11, 5'd10, 5'd12, 3'd0, 7'd0, 32'd0);
    flush = 1'b1;
    wb(1'b1, 5'd12, 32'h1234);
    step("flush_haz", 1'b0, 1'b0);
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    step("post_flush", 1'b0, 1'b1);

    // WAW on x13; set wins over same-cycle clear
    issue(OPC_OPIMM, 5'd13, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step("waw_a", 1'b0, 1'b1);
    issue(OPC_OPIMM, 5'd13, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step("waw_wait", 1'b1, 1'b0);
    wb(1'b1, 5'd13, 32'h1313);
    step("waw_clr", 1'b0, 1'b1);
    wb(1'b0, 5'd0, 32'd0);

    // LUI ignores busy rs1 field; STORE waits on busy rs2, not on rd field
    issue(OPC_LUI, 5'd14, 5'd13, 5'd13, 3'd0, 7'd0, 32'h0001_2000);
    step("lui", 1'b0, 1'b1);
    issue(OPC_STORE, 5'd5, 5'd0, 5'd14, 3'd2, 7'd0, 32'd8);
    step("sw_wait", 1'b1, 1'b0);
    wb(1'b1, 5'd14, 32'h77);
    step("sw_go", 1'b0, 1'b1);
    wb(1'b0, 5'd0, 32'd0);

    // Asynchronous reset mid-operation
    issue(OPC_OPIMM, 5'd15, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3);
    wb(1'b1, 5'd6, 32'h66);
    #2;
    reset = 1'b0;
    #1;
    chk_bit("mid_reset/valid", bus.read_valid, 1'b0);
    chk_rec("mid_reset/data", observed(), '0);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    wb(1'b0, 5'd0, 32'd0);
    bus.decode_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(OPC_OP, 5'd16, 5'd1, 5'd6, 3'd0, 7'd0, 32'd0);
    step("after_reset", 1'b0, 1'b1);
    bus.decode_valid = 1'b0;

    nvec++;
    assert (sbq.size() == 0) else begin
      nfail++;
      $error("FAIL sb_drain: observed %0d expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/regread.md
Name: regread

Overview:
- Register-read stage of the in-order RV32I pipeline. Sits between decode and execute.
- Owns the 32x32 integer register file and a per-register busy scoreboard.
- Stalls decode on RAW/WAW hazards, and presents operands plus decoded fields to execute through a one-entry pipeline register.
- Accepts register writes from the writeback stage.

Parameters:
XLEN, 32, data width of registers and operands
WB_BYPASS, 1, 1 = a same-cycle writeback to a source register supplies the operand; 0 = operand comes from the register file next cycle (the hazard stall covers it)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  kill contents of this stage and clear scoreboard
decode_valid  input  1  decode presents an instruction
decode_opcode  input  7  opcode
decode_rd  input  5  destination register
decode_rs1  input  5  source register 1
decode_rs2  input  5  source register 2
decode_funct3  input  3  funct3
decode_funct7  input  7  funct7
decode_imm  input  32  immediate
decode_pc  input  32  instruction PC
decode_exception_num  input  6  fetch/decode exception cause
decode_exception_valid  input  1  instruction carries exception
decode_stall  output  1  decode must hold its current instruction
wb_valid  input  1  writeback write enable
wb_rd  input  5  writeback register
wb_val  input  XLEN  writeback data
exec_stall  input  1  execute cannot accept new input
read_valid  output  1  outputs hold a valid instruction
read_opcode, read_rd, read_rs2, read_funct3, read_funct7, read_imm, read_pc  output  7,5,5,3,7,32,32  registered decode fields
read_rs1_val  output  XLEN  operand 1
read_rs2_val  output  XLEN  operand 2
read_exception_num  output  6  forwarded cause
read_exception_valid  output  1  forwarded exception flag

Behaviour:
- Reset (reset=0, async): all read_* outputs 0, scoreboard all clear, all 32 registers 0.
- Register file: x0 always reads 0; writes with wb_rd=0 are ignored. A wb_valid write lands at the clock edge.
- Source usage:
  - rs1 is used unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - rs2 is used only for 0110011 (OP), 0100011 (STORE) and 1100011 (BRANCH).
  - A source register x0 is never a hazard.
- rd is written for LUI, AUIPC, JAL, JALR (1100111), LOAD (0000011), OP-IMM (0010011) and OP, and only when rd!=0.
- Operand source: if WB_BYPASS=1 and wb_valid and wb_rd==rsN!=0, the operand is wb_val. Otherwise it is the register file value.
- Hazard: decode_valid, no exception, and any of:
  - a used rs has its busy bit set and is not bypassed this cycle;
  - the written rd has its busy bit set and is not being cleared this cycle.
- decode_stall = exec_stall | hazard.
- Pipeline register update:
  - exec_stall=1: hold all read_* outputs.
  - exec_stall=0 and (hazard or !decode_valid): read_valid<=0; other fields are don't-care.
  - exec_stall=0, decode_valid, no hazard: capture fields and operands; read_valid<=1. Latency is 1 cycle.
- Exception instruction: skips the hazard check and does not set busy. It is forwarded with its cause, and operands are still read.
- Scoreboard:
  - busy[rd] is set when an rd-writing instruction is captured.
  - busy[wb_rd] is cleared on wb_valid.
  - Set and clear of the same register in the same cycle: set wins.
- Flush (synchronous, highest priority):
  - read_valid<=0 and scoreboard cleared, regardless of exec_stall.
  - decode_stall is not asserted by hazard in the flush cycle.
  - Register file writes from wb_valid still occur in the flush cycle.
- Reset mid-operation: immediate return to reset state. No write in progress completes.

Test Plan:
- Reset release, then decode ADDI x1,x0,5 (OP-IMM, rs1=0) with exec_stall=0 -> next cycle read_valid=1, read_rs1_val=0, read_rd=1, busy[1]=1.
- Back-to-back ADD x2,x1,x1 after ADDI x1 -> decode_stall=1 and read_valid=0 until wb_valid wb_rd=1 wb_val=5. With WB_BYPASS=1, capture occurs in that same wb cycle with rs1_val=rs2_val=5, and busy[1] clears.
- exec_stall=1 for 3 cycles with a valid instruction held -> read_* unchanged, decode_stall=1, a decode instruction waiting behind it is not captured.
- Writes to x0 via wb (wb_val=0xDEADBEEF), then read x0 -> operand 0. An instruction with rd=0 leaves busy[0]=0.
- decode_exception_valid=1, num=2, rs1 busy -> no stall, read_exception_valid=1, read_exception_num=2, scoreboard unchanged.
- Busy x3 pending, flush=1 together with exec_stall=1 -> next cycle read_valid=0, busy all 0, and a subsequent use of x3 captures without stall.
